// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sync_fifo_pkg : default FIFO geometry and flag helper                  |
// | Revision 1.0                                                           |
// +-----------------------------------------------------------------------+
package sync_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_PTR_SIZE   = 4;

  typedef struct packed {
    logic empty;
    logic full;
  } fifo_flags_t;

  // Occupancy is wr_ptr - rd_ptr with the extra wrap bit, so it can reach depth.
  function automatic fifo_flags_t fifo_flags(input int occupancy, input int depth);
    fifo_flags_t f;
    f.empty = (occupancy == 0);
    f.full  = (occupancy == depth);
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_mem.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sync_fifo_mem : register array, sync write port, registered read port  |
// | Revision 1.0                                                           |
// +-----------------------------------------------------------------------+
module sync_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage is intentionally left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/sync_fifo_core.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sync_fifo_core : single-clock FIFO with count and error pulses         |
// | Revision 1.0                                                           |
// +-----------------------------------------------------------------------+
module sync_fifo_core
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int PTR_SIZE   = DEF_PTR_SIZE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic [PTR_SIZE:0]     count,
  output logic                  overflow,
  output logic                  underflow
);

  generate
    if (DEPTH != (1 << PTR_SIZE)) begin : g_param_check
      $error("sync_fifo_core: DEPTH must equal 2**PTR_SIZE");
    end
  endgenerate

  logic [PTR_SIZE:0] wr_ptr;
  logic [PTR_SIZE:0] rd_ptr;
  logic              rd_ok;
  logic              wr_ok;
  fifo_flags_t       flags;

  assign count = wr_ptr - rd_ptr;
  assign flags = fifo_flags(32'(count), DEPTH);
  assign empty = flags.empty;
  assign full  = flags.full;

  // A read in the same cycle frees the head slot, so a full FIFO still accepts the write.
  assign rd_ok = read_en & ~empty;
  assign wr_ok = write_en & (~full | rd_ok);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + (PTR_SIZE+1)'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + (PTR_SIZE+1)'(1);
      end
      overflow  <= write_en & ~wr_ok;
      underflow <= read_en & ~rd_ok;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (PTR_SIZE)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr[PTR_SIZE-1:0]),
    .wr_data (data_in),
    .rd_en   (rd_ok),
    .rd_addr (rd_ptr[PTR_SIZE-1:0]),
    .rd_data (data_out)
  );

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_core.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_sync_fifo_core : directed self-checking bench for sync_fifo_core    |
// | Revision 1.0                                                           |
// +-----------------------------------------------------------------------+
module tb_sync_fifo_core;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       write_en = 1'b0;
  logic       read_en = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int tests = 0;
  int fails = 0;

  sync_fifo_core #(
    .DATA_WIDTH (8),
    .DEPTH      (16),
    .PTR_SIZE   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .write_en  (write_en),
    .read_en   (read_en),
    .data_in   (data_in),
    .data_out  (data_out),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; write_en = 1'b0; read_en = 1'b0; data_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b expected 1", empty); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b expected 0", full); end
    tests++; if (count !== 5'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", count); end
    tests++; if (data_out !== 8'h00) begin fails++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
    tests++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
      fails++; $display("FAIL reset_errors: got ovf=%b udf=%b expected 0 0", overflow, underflow);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      write_en = 1'b1; data_in = 8'(i + 1);
      tick();
      tests++; if (count !== 5'(i + 1)) begin fails++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i + 1); end
    end
    tests++; if (full !== 1'b1 || empty !== 1'b0) begin
      fails++; $display("FAIL fill_flags: got full=%b empty=%b expected 1 0", full, empty);
    end
    data_in = 8'hAA;
    tick();
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL fill_overflow: got %b expected 1", overflow); end
    tests++; if (count !== 5'd16) begin fails++; $display("FAIL fill_overflow_count: got %0d expected 16", count); end
    write_en = 1'b0;
    tick();
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL fill_overflow_pulse: got %b expected 0", overflow); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      read_en = 1'b1;
      tick();
      tests++; if (data_out !== 8'(i + 1)) begin fails++; $display("FAIL drain_data[%0d]: got %h expected %h", i, data_out, 8'(i + 1)); end
    end
    tests++; if (empty !== 1'b1 || count !== 5'd0) begin
      fails++; $display("FAIL drain_empty: got empty=%b count=%0d expected 1 0", empty, count);
    end
    tick();
    tests++; if (underflow !== 1'b1) begin fails++; $display("FAIL drain_underflow: got %b expected 1", underflow); end
    tests++; if (data_out !== 8'h10) begin fails++; $display("FAIL drain_hold: got %h expected 10", data_out); end
    read_en = 1'b0;
    tick();
    tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL drain_underflow_pulse: got %b expected 0", underflow); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp;
    for (int k = 0; k < 5; k++) begin
      write_en = 1'b1; data_in = 8'(8'h20 + k);
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      write_en = 1'b1; read_en = 1'b1; data_in = 8'(8'h25 + k);
      tick();
      tests++; if (data_out !== 8'(8'h20 + k)) begin fails++; $display("FAIL simul_data[%0d]: got %h expected %h", k, data_out, 8'(8'h20 + k)); end
      tests++; if (count !== 5'd5) begin fails++; $display("FAIL simul_count[%0d]: got %0d expected 5", k, count); end
    end
    read_en = 1'b0;
    for (int k = 0; k < 11; k++) begin
      data_in = 8'(8'h2F + k);
      tick();
    end
    tests++; if (full !== 1'b1 || count !== 5'd16) begin
      fails++; $display("FAIL simul_fill: got full=%b count=%0d expected 1 16", full, count);
    end
    read_en = 1'b1; data_in = 8'h77;
    tick();
    tests++; if (data_out !== 8'h2A) begin fails++; $display("FAIL simul_full_rd: got %h expected 2a", data_out); end
    tests++; if (full !== 1'b1 || overflow !== 1'b0 || count !== 5'd16) begin
      fails++; $display("FAIL simul_full_wr: got full=%b ovf=%b count=%0d expected 1 0 16", full, overflow, count);
    end
    write_en = 1'b0;
    for (int k = 0; k < 16; k++) begin
      exp = (k < 15) ? 8'(8'h2B + k) : 8'h77;
      tick();
      tests++; if (data_out !== exp) begin fails++; $display("FAIL simul_drain[%0d]: got %h expected %h", k, data_out, exp); end
    end
    read_en = 1'b0;
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL simul_empty: got %b expected 1", empty); end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 10; k++) begin
      write_en = 1'b1; data_in = 8'(8'h40 + k);
      tick();
    end
    write_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      read_en = 1'b1;
      tick();
      tests++; if (data_out !== 8'(8'h40 + k)) begin fails++; $display("FAIL wrap_a_data[%0d]: got %h expected %h", k, data_out, 8'(8'h40 + k)); end
    end
    read_en = 1'b0;
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL wrap_a_empty: got %b expected 1", empty); end
    for (int k = 0; k < 16; k++) begin
      write_en = 1'b1; data_in = 8'(8'h80 + k);
      tick();
      tests++; if (full !== (k == 15) || empty !== 1'b0) begin
        fails++; $display("FAIL wrap_b_flags[%0d]: got full=%b empty=%b expected %b 0", k, full, empty, (k == 15));
      end
    end
    write_en = 1'b0;
    for (int k = 0; k < 16; k++) begin
      read_en = 1'b1;
      tick();
      tests++; if (data_out !== 8'(8'h80 + k)) begin fails++; $display("FAIL wrap_b_data[%0d]: got %h expected %h", k, data_out, 8'(8'h80 + k)); end
      tests++; if (empty !== (k == 15) || full !== 1'b0) begin
        fails++; $display("FAIL wrap_b_drain_flags[%0d]: got empty=%b full=%b expected %b 0", k, empty, full, (k == 15));
      end
    end
    read_en = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 7; k++) begin
      write_en = 1'b1; data_in = 8'(8'hC0 + k);
      tick();
    end
    write_en = 1'b0;
    tests++; if (count !== 5'd7) begin fails++; $display("FAIL areset_pre_count: got %0d expected 7", count); end
    #3;
    reset = 1'b0;
    #1;
    tests++; if (empty !== 1'b1 || full !== 1'b0) begin
      fails++; $display("FAIL areset_flags: got empty=%b full=%b expected 1 0", empty, full);
    end
    tests++; if (count !== 5'd0) begin fails++; $display("FAIL areset_count: got %0d expected 0", count); end
    tests++; if (data_out !== 8'h00) begin fails++; $display("FAIL areset_data_out: got %h expected 00", data_out); end
    tick();
    reset = 1'b1;
    tick();
    tests++; if (count !== 5'd0 || empty !== 1'b1) begin
      fails++; $display("FAIL areset_release: got count=%0d empty=%b expected 0 1", count, empty);
    end
    write_en = 1'b1; data_in = 8'h5A;
    tick();
    write_en = 1'b0; read_en = 1'b1;
    tick();
    read_en = 1'b0;
    tests++; if (data_out !== 8'h5A) begin fails++; $display("FAIL areset_readback: got %h expected 5a", data_out); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL areset_final_empty: got %b expected 1", empty); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_fifo_core.md
Name: sync_fifo_core

Overview:
Single-clock first-in-first-out buffer. It is parameterised in data width and depth, and stores words written by a producer until a consumer in the same clock domain reads them out. It provides registered read data, full/empty status, an occupancy count and overflow/underflow error pulses. It sits between two same-clock datapath stages as a rate-decoupling buffer.

Parameters:
- DATA_WIDTH, 8, width of each stored word in bits.
- DEPTH, 16, number of storage entries; must equal 2**PTR_SIZE.
- PTR_SIZE, 4, address width in bits; read/write pointers are PTR_SIZE+1 bits wide (extra wrap bit).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- write_en  input  1  write request; data_in is captured if the write is accepted.
- read_en  input  1  read request; the head word is popped to data_out if the read is accepted.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  registered read data.
- empty  output  1  high when occupancy is 0.
- full  output  1  high when occupancy is DEPTH.
- count  output  PTR_SIZE+1  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse when a write is rejected.
- underflow  output  1  one-cycle pulse when a read is rejected.

Behaviour:
Reset:
- Asserting reset low immediately, without waiting for a clock edge, clears wr_ptr, rd_ptr, count, data_out, overflow and underflow to 0, and sets empty=1, full=0.
- Memory contents are not cleared.
- Reset asserted mid-operation discards all stored data; the FIFO is empty on release.

Accept rules, evaluated on each rising edge from pre-edge state:
- rd_ok = read_en & !empty.
- wr_ok = write_en & (!full | rd_ok).

Write:
- If wr_ok: mem[wr_ptr[PTR_SIZE-1:0]] <= data_in, then wr_ptr increments.
- If write_en & !wr_ok: no state change to the memory or pointers; overflow=1 for one cycle.

Read:
- If rd_ok: data_out <= mem[rd_ptr[PTR_SIZE-1:0]] (one-cycle latency, valid after the edge), then rd_ptr increments.
- If read_en & !rd_ok: data_out holds its value; underflow=1 for one cycle.
- data_out holds its last value whenever no read is accepted.

Simultaneous read and write:
- Both accepted: count is unchanged.
- When full, both proceed: the read takes the old head word, and the write fills the slot that frees up.
- When empty, only the write proceeds; there is no write-to-read bypass.

Pointers and flags:
- Pointers wrap modulo 2*DEPTH naturally.
- empty = (wr_ptr == rd_ptr).
- full = (address bits equal) & (wrap bits differ).
- count = wr_ptr - rd_ptr, computed modulo 2**(PTR_SIZE+1).
- All flags are combinational from the registered pointers and update in the cycle after the accepted operation.

Ordering:
- Strict FIFO; data reads back in write order across pointer wrap-around.

Decomposition:
- Package sync_fifo_pkg: default DATA_WIDTH/DEPTH/PTR_SIZE constants and a helper function for count/full/empty computation.
- Sub-module sync_fifo_mem: a DEPTH x DATA_WIDTH register array with a synchronous write port and a synchronous registered read port (wr_en, wr_addr, wr_data, rd_en, rd_addr, rd_data).
- The top level holds the pointers, flags and error pulses.

Test Plan:
1. Reset: hold reset=0 for 2 cycles, then release -> empty=1, full=0, count=0, data_out=0, no error pulses.
2. Fill: write 16 words 0x01..0x10 on consecutive cycles -> after the 16th edge, full=1, count=16, empty=0; then write 0xAA -> overflow pulses once, count stays 16, and 0xAA is never read back.
3. Drain: 16 consecutive reads -> data_out = 0x01..0x10 in order, one cycle after each read edge; empty=1 after the last read; a 17th read -> underflow pulse, data_out holds 0x10.
4. Simultaneous: with 5 words stored, assert write_en and read_en for 10 cycles -> count stays 5 and the output order is preserved; when full, read+write together -> both accepted, full stays 1, no overflow.
5. Wrap-around: write 10, read 10, write 16, read 16 (pointers cross the DEPTH boundary) -> all data matches write order, and full/empty are correct throughout.
6. Async reset mid-operation: with 7 words stored, pull reset low between clock edges -> empty=1, count=0 and data_out=0 before the next edge; after release, a subsequent write of 0x5A then a read returns 0x5A.
